exec_sequencer: RTL and testbench
=================================

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have parameter Width, default 32: datapath width of instruction, PC, operands.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1: synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port instr_valid  in  1: instr/pc/rs1_data/rs2_data valid this cycle.
REQ-005 SHALL have port instr_ready  out  1: sequencer accepts an instruction this cycle.
REQ-006 SHALL have port instr  in  32: RV32IM instruction word.
REQ-007 SHALL have port pc  in  Width: address of instr.
REQ-008 SHALL have ports rs1_data, rs2_data  in  Width: register-file read values for instr.
REQ-009 SHALL have port mem_ready  in  1: data memory has completed the current load/store.
REQ-010 SHALL have port counter  out  3: phase code driven to the ALU counter input.
REQ-011 SHALL have port alu_ctrl  out  4: ALU control code.
REQ-012 SHALL have ports alu_a, alu_b  out  Width: ALU operands A1, A2.
REQ-013 SHALL have port wb_en  out  1: one-cycle register write-back strobe.
REQ-014 SHALL have port illegal  out  1: latched unsupported-opcode flag for the current instruction.

Function
REQ-015 SHALL run phases FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; counter SHALL equal the phase code.
REQ-016 SHALL, in FETCH: instr_ready=1; on instr_valid, capture instr/pc/rs1_data/rs2_data and go to DECODE; otherwise hold FETCH.
REQ-017 SHALL, in DECODE: register alu_ctrl/alu_a/alu_b from captured fields, go to EXEC next cycle; instr_ready=0 outside FETCH.
REQ-018 SHALL keep alu_ctrl/alu_a/alu_b constant from EXEC entry until the next DECODE; the ALU samples on counter change to 2.
REQ-019 SHALL decode R-type (0110011): ADD 0010, SUB 0110, SLL 0011, SLT 0101, SLTU 0100, XOR 0111, SRL 1000, SRA 1010, OR 0001, AND 0000; funct7=0000001: MUL 1110, DIV 1101, REM 1011; operands rs1, rs2.
REQ-020 SHALL decode I-type ALU (0010011) with the same funct3 map, SRAI on imm[10]=1; operand B = sign-extended imm[11:0], shifts use shamt zero-extended.
REQ-021 SHALL decode load (0000011)/store (0100011) as ADD rs1+imm (store imm = {instr[31:25],instr[11:7]} sign-extended).
REQ-022 SHALL decode branch (1100011) as EQ 1111 on rs1, rs2; LUI as ADD 0 + {imm[31:12],12'b0}; AUIPC as ADD pc + same.
REQ-023 SHALL, for any other opcode or unlisted funct combination, drive alu_ctrl=1001, set illegal=1, and suppress wb_en.
REQ-024 SHALL transition from EXEC: load/store -> MEM; all others -> WB.
REQ-025 SHALL hold MEM while mem_ready=0; on mem_ready=1 go to WB; mem_ready outside MEM SHALL be ignored.
REQ-026 SHALL, in WB, assert wb_en for exactly one cycle unless store, branch, or illegal; then return to FETCH.
REQ-027 SHALL yield minimum latency of 4 cycles (FETCH accept to FETCH) for non-memory instructions, 5 + wait cycles for memory.
REQ-028 SHALL clear illegal on next instruction acceptance.
REQ-029 SHALL never present counter values 5-7.

Reset
REQ-030 SHALL, when rst_n=0 at a clk edge (including mid-instruction, e.g. in MEM), set phase FETCH, counter=0, alu_ctrl=1001, alu_a=alu_b=0, wb_en=0, illegal=0, instr_ready=1, abandoning the in-flight instruction with no wb_en.

Structure
REQ-031 SHALL place ALU control codes and phase codes in shared package alu_pkg, also used by the ALU.
REQ-032 SHALL implement opcode/funct-to-control/operand selection as combinational sub-module alu_decode; phase FSM and registers in exec_sequencer.

Verification
REQ-033 SHALL check reset: rst_n=0 one cycle -> counter=0, alu_ctrl=1001, instr_ready=1, wb_en=0.
REQ-034 SHALL check ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> counter 0,1,2,4,0; alu_ctrl=0010, alu_a=5, alu_b=7 in EXEC; wb_en=1 only in WB.
REQ-035 SHALL check SRAI imm 0x403, rs1=0x80000000 -> alu_ctrl=1010, alu_b=3; ADDI imm 0xFFF -> alu_b=0xFFFFFFFF.
REQ-036 SHALL check LW with mem_ready low 3 cycles -> counter held at 3 for 4 cycles, then 4 with wb_en=1; SW -> WB with wb_en=0.
REQ-037 SHALL check opcode 0x7F -> alu_ctrl=1001, illegal=1, no wb_en; following ADD clears illegal.
REQ-038 SHALL check rst_n=0 during MEM -> next cycle counter=0, no wb_en, next instruction runs normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, sequencer phase codes and RV32 opcode constants
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_XOR  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_NOP  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_REM  = 4'b1011,
        ALU_DIV  = 4'b1101,
        ALU_MUL  = 4'b1110,
        ALU_EQ   = 4'b1111
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Shared funct3 map for register and immediate ALU forms; alt selects SUB/SRA.
    function automatic alu_ctrl_e funct3_ctrl(input logic [2:0] f3, input logic alt);
        alu_ctrl_e c;
        case (f3)
            3'b000:  c = alt ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = alt ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational opcode/funct decode to ALU control and operand selection
module alu_decode
    import alu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [31:0]      instr,
    input  logic [Width-1:0] pc,
    input  logic [Width-1:0] rs1_data,
    input  logic [Width-1:0] rs2_data,
    output alu_ctrl_e        alu_ctrl,
    output logic [Width-1:0] alu_a,
    output logic [Width-1:0] alu_b,
    output logic             illegal,
    output logic             is_mem,
    output logic             no_wb
);

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [Width-1:0] imm_i;
    logic [Width-1:0] imm_s;
    logic [Width-1:0] imm_u;
    logic [Width-1:0] shamt;
    logic             unused_fields;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign imm_i         = Width'($signed(instr[31:20]));
    assign imm_s         = Width'($signed({instr[31:25], instr[11:7]}));
    assign imm_u         = Width'($signed({instr[31:12], 12'b0}));
    assign shamt         = Width'(instr[24:20]);
    assign unused_fields = ^instr[19:15];

    always_comb begin
        alu_ctrl = ALU_NOP;
        alu_a    = '0;
        alu_b    = '0;
        illegal  = 1'b1;
        is_mem   = 1'b0;
        no_wb    = 1'b0;
        case (opcode)
            OP_R: begin
                alu_a = rs1_data;
                alu_b = rs2_data;
                if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000: begin alu_ctrl = ALU_MUL; illegal = 1'b0; end
                        3'b100: begin alu_ctrl = ALU_DIV; illegal = 1'b0; end
                        3'b110: begin alu_ctrl = ALU_REM; illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))) begin
                    alu_ctrl = funct3_ctrl(f3, f7[5]);
                    illegal  = 1'b0;
                end
            end
            OP_IMM: begin
                alu_a = rs1_data;
                if (f3 == 3'b001) begin
                    alu_b = shamt;
                    if (f7 == F7_BASE) begin
                        alu_ctrl = ALU_SLL;
                        illegal  = 1'b0;
                    end
                end else if (f3 == 3'b101) begin
                    alu_b = shamt;
                    if (f7 == F7_BASE || f7 == F7_ALT) begin
                        alu_ctrl = funct3_ctrl(f3, f7[5]);
                        illegal  = 1'b0;
                    end
                end else begin
                    // ADDI has no SUB form, so the alt bit is never applied here.
                    alu_b    = imm_i;
                    alu_ctrl = funct3_ctrl(f3, 1'b0);
                    illegal  = 1'b0;
                end
            end
            OP_LOAD: begin
                if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                    alu_ctrl = ALU_ADD;
                    alu_a    = rs1_data;
                    alu_b    = imm_i;
                    is_mem   = 1'b1;
                    illegal  = 1'b0;
                end
            end
            OP_STORE: begin
                if (f3[2] == 1'b0 && f3 != 3'b011) begin
                    alu_ctrl = ALU_ADD;
                    alu_a    = rs1_data;
                    alu_b    = imm_s;
                    is_mem   = 1'b1;
                    no_wb    = 1'b1;
                    illegal  = 1'b0;
                end
            end
            OP_BRANCH: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    alu_ctrl = ALU_EQ;
                    alu_a    = rs1_data;
                    alu_b    = rs2_data;
                    no_wb    = 1'b1;
                    illegal  = 1'b0;
                end
            end
            OP_LUI: begin
                alu_ctrl = ALU_ADD;
                alu_b    = imm_u;
                illegal  = 1'b0;
            end
            OP_AUIPC: begin
                alu_ctrl = ALU_ADD;
                alu_a    = pc;
                alu_b    = imm_u;
                illegal  = 1'b0;
            end
            default: ;
        endcase
        // An unsupported funct combination must not leak a partial decode.
        if (illegal) begin
            alu_ctrl = ALU_NOP;
            is_mem   = 1'b0;
            no_wb    = 1'b0;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - five-phase instruction sequencer driving ALU control, operands and write-back
module exec_sequencer
    import alu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [Width-1:0] pc,
    input  logic [Width-1:0] rs1_data,
    input  logic [Width-1:0] rs2_data,
    input  logic             mem_ready,
    output logic [2:0]       counter,
    output logic [3:0]       alu_ctrl,
    output logic [Width-1:0] alu_a,
    output logic [Width-1:0] alu_b,
    output logic             wb_en,
    output logic             illegal
);

    phase_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [Width-1:0] pc_q, pc_d;
    logic [Width-1:0] rs1_q, rs1_d;
    logic [Width-1:0] rs2_q, rs2_d;
    alu_ctrl_e        alu_ctrl_q, alu_ctrl_d;
    logic [Width-1:0] alu_a_q, alu_a_d;
    logic [Width-1:0] alu_b_q, alu_b_d;
    logic             illegal_q, illegal_d;

    alu_ctrl_e        dec_ctrl;
    logic [Width-1:0] dec_a;
    logic [Width-1:0] dec_b;
    logic             dec_illegal;
    logic             dec_is_mem;
    logic             dec_no_wb;

    // Decode runs on the captured word, which is stable until the next FETCH accept.
    alu_decode #(.Width(Width)) u_decode (
        .instr    (instr_q),
        .pc       (pc_q),
        .rs1_data (rs1_q),
        .rs2_data (rs2_q),
        .alu_ctrl (dec_ctrl),
        .alu_a    (dec_a),
        .alu_b    (dec_b),
        .illegal  (dec_illegal),
        .is_mem   (dec_is_mem),
        .no_wb    (dec_no_wb)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        illegal_d   = illegal_q;
        instr_ready = 1'b0;
        case (state_q)
            PH_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d   = instr;
                    pc_d      = pc;
                    rs1_d     = rs1_data;
                    rs2_d     = rs2_data;
                    illegal_d = 1'b0;
                    state_d   = PH_DECODE;
                end
            end
            PH_DECODE: begin
                alu_ctrl_d = dec_ctrl;
                alu_a_d    = dec_a;
                alu_b_d    = dec_b;
                illegal_d  = dec_illegal;
                state_d    = PH_EXEC;
            end
            PH_EXEC: begin
                state_d = dec_is_mem ? PH_MEM : PH_WB;
            end
            PH_MEM: begin
                if (mem_ready) begin
                    state_d = PH_WB;
                end
            end
            PH_WB: begin
                state_d = PH_FETCH;
            end
            default: begin
                state_d = PH_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PH_FETCH;
            instr_q    <= '0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            alu_ctrl_q <= ALU_NOP;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            alu_ctrl_q <= alu_ctrl_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            illegal_q  <= illegal_d;
        end
    end

    assign counter  = state_q;
    assign alu_ctrl = alu_ctrl_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign illegal  = illegal_q;
    assign wb_en    = (state_q == PH_WB) && !dec_no_wb && !illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed self-checking bench for exec_sequencer
module tb_exec_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        mem_ready;
    logic [2:0]  counter;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        wb_en;
    logic        illegal;

    int vectors;
    int miscompares;

    exec_sequencer #(.Width(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .mem_ready   (mem_ready),
        .counter     (counter),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .wb_en       (wb_en),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] pcv,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] ectrl, input logic [31:0] ea, input logic [31:0] eb,
                             input bit eops, input bit emem, input bit ewb, input bit eill);
        check({name, "/fetch_counter"}, 32'(counter), 32'd0);
        check({name, "/fetch_ready"}, 32'(instr_ready), 32'd1);
        instr       = ins;
        pc          = pcv;
        rs1_data    = a;
        rs2_data    = b;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check({name, "/decode_counter"}, 32'(counter), 32'd1);
        check({name, "/decode_ready"}, 32'(instr_ready), 32'd0);
        check({name, "/decode_illegal"}, 32'(illegal), 32'd0);
        @(negedge clk);
        check({name, "/exec_counter"}, 32'(counter), 32'd2);
        check({name, "/exec_ctrl"}, 32'(alu_ctrl), ectrl);
        check({name, "/exec_illegal"}, 32'(illegal), 32'(eill));
        check({name, "/exec_wb"}, 32'(wb_en), 32'd0);
        if (eops) begin
            check({name, "/exec_a"}, alu_a, ea);
            check({name, "/exec_b"}, alu_b, eb);
        end
        if (emem) begin
            @(negedge clk);
            check({name, "/mem_counter"}, 32'(counter), 32'd3);
            check({name, "/mem_wb"}, 32'(wb_en), 32'd0);
        end
        @(negedge clk);
        check({name, "/wb_counter"}, 32'(counter), 32'd4);
        check({name, "/wb_en"}, 32'(wb_en), 32'(ewb));
        @(negedge clk);
        check({name, "/ret_counter"}, 32'(counter), 32'd0);
        check({name, "/ret_wb"}, 32'(wb_en), 32'd0);
    endtask

    logic [31:0] r_instr [7] = '{32'h402081B3, 32'h022081B3, 32'h0220C1B3, 32'h0220E1B3,
                                 32'h0020B1B3, 32'h0020C1B3, 32'h022091B3};
    logic [31:0] r_ctrl  [7] = '{32'h6, 32'hE, 32'hD, 32'hB, 32'h4, 32'h7, 32'h9};
    bit          r_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        pc          = '0;
        rs1_data    = '0;
        rs2_data    = '0;
        mem_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset/counter", 32'(counter), 32'd0);
        check("reset/alu_ctrl", 32'(alu_ctrl), 32'h9);
        check("reset/ready", 32'(instr_ready), 32'd1);
        check("reset/wb_en", 32'(wb_en), 32'd0);
        check("reset/illegal", 32'(illegal), 32'd0);
        check("reset/alu_a", alu_a, 32'd0);
        check("reset/alu_b", alu_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle/counter", 32'(counter), 32'd0);

        run_instr("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h2, 32'd5, 32'd7, 1, 0, 1, 0);
        run_instr("srai", 32'h4030D113, 32'h4, 32'h80000000, 32'h0, 32'hA, 32'h80000000, 32'd3, 1, 0, 1, 0);
        run_instr("addi", 32'hFFF08113, 32'h8, 32'd9, 32'h0, 32'h2, 32'd9, 32'hFFFFFFFF, 1, 0, 1, 0);
        for (int i = 0; i < 7; i++) begin
            run_instr($sformatf("rtype%0d", i), r_instr[i], 32'h10, 32'h11, 32'h22,
                      r_ctrl[i], 32'h11, 32'h22, !r_ill[i], 0, !r_ill[i], r_ill[i]);
        end
        run_instr("beq", 32'h00208063, 32'h20, 32'd3, 32'd3, 32'hF, 32'd3, 32'd3, 1, 0, 0, 0);
        run_instr("lui", 32'h123450B7, 32'h24, 32'h55, 32'h0, 32'h2, 32'h0, 32'h12345000, 1, 0, 1, 0);
        run_instr("auipc", 32'h12345097, 32'h1000, 32'h55, 32'h0, 32'h2, 32'h1000, 32'h12345000, 1, 0, 1, 0);
        run_instr("sw", 32'h0020A223, 32'h28, 32'h200, 32'h0, 32'h2, 32'h200, 32'd4, 1, 1, 0, 0);

        // LW with three wait cycles; mem_ready high before MEM is ignored
        instr       = 32'h0080A103;
        rs1_data    = 32'h100;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("lw/decode_counter", 32'(counter), 32'd1);
        @(negedge clk);
        check("lw/exec_counter", 32'(counter), 32'd2);
        check("lw/exec_a", alu_a, 32'h100);
        check("lw/exec_b", alu_b, 32'd8);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lw/mem_hold%0d", i), 32'(counter), 32'd3);
            check($sformatf("lw/mem_wb%0d", i), 32'(wb_en), 32'd0);
            mem_ready = (i == 3);
            @(negedge clk);
        end
        check("lw/wb_counter", 32'(counter), 32'd4);
        check("lw/wb_en", 32'(wb_en), 32'd1);
        @(negedge clk);
        check("lw/ret_counter", 32'(counter), 32'd0);

        run_instr("ill7f", 32'h0000007F, 32'h30, 32'h1, 32'h2, 32'h9, 32'h0, 32'h0, 0, 0, 0, 1);
        check("ill7f/held_illegal", 32'(illegal), 32'd1);
        run_instr("add_clr", 32'h002081B3, 32'h34, 32'd1, 32'd2, 32'h2, 32'd1, 32'd2, 1, 0, 1, 0);
        check("add_clr/illegal", 32'(illegal), 32'd0);

        // reset while an LW is waiting in MEM
        instr       = 32'h0080A103;
        rs1_data    = 32'h300;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rstmem/in_mem", 32'(counter), 32'd3);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rstmem/counter", 32'(counter), 32'd0);
        check("rstmem/wb_en", 32'(wb_en), 32'd0);
        check("rstmem/alu_ctrl", 32'(alu_ctrl), 32'h9);
        check("rstmem/alu_a", alu_a, 32'd0);
        check("rstmem/ready", 32'(instr_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmem/idle", 32'(counter), 32'd0);
        check("rstmem/idle_wb", 32'(wb_en), 32'd0);
        run_instr("add_post", 32'h002081B3, 32'h40, 32'd20, 32'd22, 32'h2, 32'd20, 32'd22, 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
